vga_menu_engine: RTL and testbench
==================================

VGA_MENU_ENGINE -- requirements
Module: vga_menu_engine

Interface
REQ-001 SHALL have parameter NUM_OPTIONS, default 5, meaning the number of selectable menu entries (legal range 1..8).
REQ-002 SHALL have parameter ROWS, default 3, meaning options per column; option i sits at column i/ROWS, row i%ROWS.
REQ-003 SHALL have parameter CHARS, default 7, meaning glyph slots per option label.
REQ-004 SHALL have parameter BLINK_FRAMES, default 30, meaning frames per selection-box blink phase.
REQ-005 SHALL have port clock, input, 1, system clock.
REQ-006 SHALL have port reset, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port curAddress, input, 19, pixel address; x = addr mod 640, y = addr div 640.
REQ-008 SHALL have port indexIn, input, 8, palette index read at the previous cycle's addrToRead.
REQ-009 SHALL have port colorIn, input, 24, colour aligned with indexIn.
REQ-010 SHALL have ports btn_up, btn_down, btn_left, btn_right and btn_enter, each input, 1, level button, synchronous to clock.
REQ-011 SHALL have port sel_ack, input, 1, consumer acknowledge of a confirmed selection.
REQ-012 SHALL have port addrToRead, output, 19, image-memory address.
REQ-013 SHALL have port indexOut, output, 8, final palette index.
REQ-014 SHALL have port colorOut, output, 24, final colour.
REQ-015 SHALL have port sel_index, output, 3, current highlighted option.
REQ-016 SHALL have port sel_valid, output, 1, confirmed-selection strobe (held).

Function
REQ-017 SHALL register addrToRead one cycle after curAddress; labels: glyph slot k of option i at x0 = 133 + 227*col + 21*k, y0 = 227 + 58*row, size 21x25; address = 307200 + 525*code + (x-x0) + 21*(y-y0); code 0 = blank -> 1923.
REQ-018 SHALL map pixels in logo window x 204..434, y 40..195 to 25940 + (x-204) + 640*(y-40); all other pixels -> 1923.
REQ-019 SHALL register indexOut/colorOut one cycle after indexIn/colorIn, using overlay decisions from curAddress delayed two cycles so overlay and data align; total curAddress-to-indexOut latency 2.
REQ-020 SHALL force indexOut = 7 for the 3-pixel screen border (x<3, x>636, y<3, y>476) and, when the box is visible, the 3-pixel outline of a 153x31 box at (130 + 227*col, 224 + 58*row) of sel_index; otherwise pass indexIn; colorOut always passes colorIn delayed.
REQ-021 SHALL act on button rising edges only (one-cycle registered edge detect); multiple edges in one cycle: priority enter > up > down > left > right, others dropped.
REQ-022 SHALL implement FSM NAV and HOLD: NAV + enter edge -> HOLD with sel_valid = 1 next cycle; HOLD + sel_ack -> NAV with sel_valid = 0 next cycle; in HOLD all navigation ignored and sel_index frozen.
REQ-023 SHALL wrap up/down within the current column (row 0 up -> last populated row; last row down -> row 0).
REQ-024 SHALL wrap left/right across columns with the same row; a target index >= NUM_OPTIONS leaves sel_index unchanged.
REQ-025 SHALL count frames on curAddress == 0 (counter clears at BLINK_FRAMES-1 and toggles blink phase); the box is visible in phase 0 or in HOLD.
REQ-026 SHALL treat sel_ack while in NAV as a no-op.

Reset
REQ-027 SHALL, on reset, asynchronously force state NAV, sel_index 0, sel_valid 0, addrToRead 1923, indexOut 0, colorOut 0, blink counter and phase 0, edge-detect history 0 (held buttons produce no edge after release of reset).
REQ-028 SHALL, on reset asserted in HOLD, drop sel_valid immediately with no ack required.

Structure
REQ-029 SHALL place screen constants (640, 307200, 525, 1923, 25940, glyph 21x25, box geometry, border index 7) in shared package vga_menu_pkg.
REQ-030 SHALL place label character codes in sub-module vga_menu_label_rom (option, slot -> 6-bit code, combinational).

Verification
REQ-031 SHALL verify: reset, then btn_down pulse x2 -> sel_index 0->1->2; third pulse -> 0.
REQ-032 SHALL verify: sel_index 1, btn_right -> 4; sel_index 2, btn_right -> unchanged 2 (index 5 absent).
REQ-033 SHALL verify: btn_enter -> sel_valid 1 next cycle; btn_down during HOLD -> no change; sel_ack -> sel_valid 0, NAV.
REQ-034 SHALL verify: curAddress = 227*640+133 with sel 0 -> addrToRead 307200+13125 after 1 cycle; pixel (130,224) -> indexOut 7 after 2 cycles when visible.
REQ-035 SHALL verify: btn_up and btn_enter rising same cycle -> HOLD, sel_index unchanged.
REQ-036 SHALL verify: 30 frames of curAddress==0 -> box hidden (indexOut = indexIn at box pixel); reset mid-HOLD -> sel_valid 0 asynchronously.

Source files
------------

// File: rtl/vga_menu_pkg.sv
// Screen geometry, memory map and shared types for the VGA menu overlay engine.
package vga_menu_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;

    localparam int GLYPH_BASE   = 307200;
    localparam int GLYPH_STRIDE = 525;
    localparam int GLYPH_W      = 21;
    localparam int GLYPH_H      = 25;
    localparam int BLANK_ADDR   = 1923;

    localparam int LOGO_BASE    = 25940;
    localparam int LOGO_X0      = 204;
    localparam int LOGO_X1      = 434;
    localparam int LOGO_Y0      = 40;
    localparam int LOGO_Y1      = 195;

    localparam int LABEL_X0     = 133;
    localparam int LABEL_Y0     = 227;
    localparam int COL_PITCH    = 227;
    localparam int ROW_PITCH    = 58;

    localparam int BOX_X0       = 130;
    localparam int BOX_Y0       = 224;
    localparam int BOX_W        = 153;
    localparam int BOX_H        = 31;
    localparam int OUTLINE_W    = 3;
    localparam int BORDER_W     = 3;

    localparam logic [7:0] BORDER_INDEX = 8'd7;

    typedef enum logic {
        ST_NAV,
        ST_HOLD
    } menu_state_e;

    typedef enum logic [2:0] {
        BTN_NONE,
        BTN_ENTER,
        BTN_UP,
        BTN_DOWN,
        BTN_LEFT,
        BTN_RIGHT
    } btn_cmd_e;

    // Glyph codes: 0 blank, '0'..'9' -> 1..10, 'A'..'Z' -> 11..36.
    function automatic logic [5:0] char_code(input logic [7:0] c);
        logic [5:0] code;
        code = 6'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            code = 6'(c - 8'h30) + 6'd1;
        end else if (c >= 8'h41 && c <= 8'h5A) begin
            code = 6'(c - 8'h41) + 6'd11;
        end
        return code;
    endfunction

endpackage

// File: rtl/vga_menu_label_rom.sv
// Label text for each menu option; returns the glyph code for one character slot.
module vga_menu_label_rom
    import vga_menu_pkg::*;
(
    input  logic [2:0] option_i,
    input  logic [3:0] slot_i,
    output logic [5:0] code_o
);

    localparam int LABEL_LEN = 7;

    logic [8*LABEL_LEN-1:0] text;

    always_comb begin
        case (option_i)
            3'd0:    text = "OPEN   ";
            3'd1:    text = "SAVE   ";
            3'd2:    text = "LOAD   ";
            3'd3:    text = "CONFIG ";
            3'd4:    text = "EXIT   ";
            3'd5:    text = "OPTION5";
            3'd6:    text = "OPTION6";
            default: text = "OPTION7";
        endcase

        // Slots past the stored text render as blank.
        code_o = 6'd0;
        for (int k = 0; k < LABEL_LEN; k++) begin
            if (slot_i == 4'(k)) begin
                code_o = char_code(text[8*(LABEL_LEN-1-k) +: 8]);
            end
        end
    end

endmodule

// File: rtl/vga_menu_engine.sv
// Menu overlay for a 640x480 pixel stream: label/logo address generation,
// border and blinking selection box overlay, and button-driven selection FSM.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_NAV  | browsing; button edges move sel_index, enter confirms
//   ST_HOLD | selection confirmed, sel_valid held high until sel_ack
module vga_menu_engine
    import vga_menu_pkg::*;
#(
    parameter int NUM_OPTIONS  = 5,
    parameter int ROWS         = 3,
    parameter int CHARS        = 7,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] curAddress,
    input  logic [7:0]  indexIn,
    input  logic [23:0] colorIn,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    input  logic        sel_ack,
    output logic [18:0] addrToRead,
    output logic [7:0]  indexOut,
    output logic [23:0] colorOut,
    output logic [2:0]  sel_index,
    output logic        sel_valid
);

    localparam int NUM_COLS = (NUM_OPTIONS + ROWS - 1) / ROWS;
    localparam int CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    menu_state_e      state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic [18:0]      addr_q, addr_d;
    logic             ovl_q, ovl_d;
    logic [7:0]       index_q;
    logic [23:0]      color_q;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [4:0]       btn_hist_q;
    logic             armed_q;

    logic [9:0]       pix_x;
    logic [9:0]       pix_y;

    always_comb begin
        pix_x = 10'(curAddress % 19'(SCREEN_W));
        pix_y = 10'(curAddress / 19'(SCREEN_W));
    end

    // ---------------- label / logo address generation ----------------
    logic       lbl_hit;
    logic [2:0] lbl_opt;
    logic [3:0] lbl_slot;
    logic [4:0] lbl_dx;
    logic [4:0] lbl_dy;
    logic [5:0] lbl_code;

    always_comb begin
        lbl_hit  = 1'b0;
        lbl_opt  = 3'd0;
        lbl_slot = 4'd0;
        lbl_dx   = 5'd0;
        lbl_dy   = 5'd0;
        for (int i = 0; i < NUM_OPTIONS; i++) begin
            for (int k = 0; k < CHARS; k++) begin
                if (int'(pix_x) >= LABEL_X0 + COL_PITCH*(i/ROWS) + GLYPH_W*k &&
                    int'(pix_x) <  LABEL_X0 + COL_PITCH*(i/ROWS) + GLYPH_W*(k+1) &&
                    int'(pix_y) >= LABEL_Y0 + ROW_PITCH*(i%ROWS) &&
                    int'(pix_y) <  LABEL_Y0 + ROW_PITCH*(i%ROWS) + GLYPH_H) begin
                    lbl_hit  = 1'b1;
                    lbl_opt  = 3'(i);
                    lbl_slot = 4'(k);
                    lbl_dx   = 5'(int'(pix_x) - (LABEL_X0 + COL_PITCH*(i/ROWS) + GLYPH_W*k));
                    lbl_dy   = 5'(int'(pix_y) - (LABEL_Y0 + ROW_PITCH*(i%ROWS)));
                end
            end
        end
    end

    vga_menu_label_rom u_label_rom (
        .option_i (lbl_opt),
        .slot_i   (lbl_slot),
        .code_o   (lbl_code)
    );

    always_comb begin
        addr_d = 19'(BLANK_ADDR);
        if (lbl_hit) begin
            if (lbl_code != 6'd0) begin
                addr_d = 19'(GLYPH_BASE + GLYPH_STRIDE*int'(lbl_code) +
                             int'(lbl_dx) + GLYPH_W*int'(lbl_dy));
            end
        end else if (int'(pix_x) >= LOGO_X0 && int'(pix_x) <= LOGO_X1 &&
                     int'(pix_y) >= LOGO_Y0 && int'(pix_y) <= LOGO_Y1) begin
            addr_d = 19'(LOGO_BASE + (int'(pix_x) - LOGO_X0) +
                         SCREEN_W*(int'(pix_y) - LOGO_Y0));
        end
    end

    // ---------------- border / selection box overlay ----------------
    int   box_x0;
    int   box_y0;
    logic in_box;
    logic on_outline;
    logic on_border;
    logic box_visible;

    always_comb begin
        box_x0 = BOX_X0 + COL_PITCH*(int'(sel_q) / ROWS);
        box_y0 = BOX_Y0 + ROW_PITCH*(int'(sel_q) % ROWS);
        in_box = int'(pix_x) >= box_x0 && int'(pix_x) < box_x0 + BOX_W &&
                 int'(pix_y) >= box_y0 && int'(pix_y) < box_y0 + BOX_H;
        on_outline = in_box &&
                     (int'(pix_x) <  box_x0 + OUTLINE_W ||
                      int'(pix_x) >= box_x0 + BOX_W - OUTLINE_W ||
                      int'(pix_y) <  box_y0 + OUTLINE_W ||
                      int'(pix_y) >= box_y0 + BOX_H - OUTLINE_W);
        on_border = int'(pix_x) <  BORDER_W || int'(pix_x) >= SCREEN_W - BORDER_W ||
                    int'(pix_y) <  BORDER_W || int'(pix_y) >= SCREEN_H - BORDER_W;
        box_visible = !blink_phase_q || (state_q == ST_HOLD);
        ovl_d = on_border || (box_visible && on_outline);
    end

    // A frame starts whenever the scan is at address 0.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (curAddress == 19'd0) begin
            if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- buttons ----------------
    logic [4:0] btn_now;
    logic [4:0] btn_rise;
    btn_cmd_e   cmd;

    // armed_q suppresses the first cycle so a button held through reset is not an edge.
    assign btn_now  = {btn_enter, btn_up, btn_down, btn_left, btn_right};
    assign btn_rise = armed_q ? (btn_now & ~btn_hist_q) : 5'b0;

    always_comb begin
        cmd = BTN_NONE;
        if (btn_rise[4]) begin
            cmd = BTN_ENTER;
        end else if (btn_rise[3]) begin
            cmd = BTN_UP;
        end else if (btn_rise[2]) begin
            cmd = BTN_DOWN;
        end else if (btn_rise[1]) begin
            cmd = BTN_LEFT;
        end else if (btn_rise[0]) begin
            cmd = BTN_RIGHT;
        end
    end

    int cur_col;
    int cur_row;
    int col_rows;
    int nav_target;

    always_comb begin
        cur_col  = int'(sel_q) / ROWS;
        cur_row  = int'(sel_q) % ROWS;
        col_rows = NUM_OPTIONS - cur_col*ROWS;
        if (col_rows > ROWS) begin
            col_rows = ROWS;
        end
        nav_target = int'(sel_q);
        case (cmd)
            BTN_UP:    nav_target = cur_col*ROWS + ((cur_row == 0) ? col_rows - 1 : cur_row - 1);
            BTN_DOWN:  nav_target = cur_col*ROWS + ((cur_row == col_rows - 1) ? 0 : cur_row + 1);
            BTN_LEFT:  nav_target = ((cur_col == 0) ? NUM_COLS - 1 : cur_col - 1)*ROWS + cur_row;
            BTN_RIGHT: nav_target = ((cur_col == NUM_COLS - 1) ? 0 : cur_col + 1)*ROWS + cur_row;
            default:   nav_target = int'(sel_q);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        unique case (state_q)
            ST_NAV: begin
                if (cmd == BTN_ENTER) begin
                    state_d     = ST_HOLD;
                    sel_valid_d = 1'b1;
                end else if (cmd != BTN_NONE && nav_target < NUM_OPTIONS) begin
                    sel_d = 3'(nav_target);
                end
            end
            ST_HOLD: begin
                if (sel_ack) begin
                    state_d     = ST_NAV;
                    sel_valid_d = 1'b0;
                end
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_NAV;
            sel_q         <= 3'd0;
            sel_valid_q   <= 1'b0;
            addr_q        <= 19'(BLANK_ADDR);
            ovl_q         <= 1'b0;
            index_q       <= 8'd0;
            color_q       <= 24'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            btn_hist_q    <= 5'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            sel_valid_q   <= sel_valid_d;
            addr_q        <= addr_d;
            ovl_q         <= ovl_d;
            index_q       <= ovl_q ? BORDER_INDEX : indexIn;
            color_q       <= colorIn;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            btn_hist_q    <= btn_now;
            armed_q       <= 1'b1;
        end
    end

    assign addrToRead = addr_q;
    assign indexOut   = index_q;
    assign colorOut   = color_q;
    assign sel_index  = sel_q;
    assign sel_valid  = sel_valid_q;

endmodule

// File: tb/tb_vga_menu_engine.sv
// Directed bench for vga_menu_engine: navigation FSM plus a pixel scoreboard
// fed by a combinational image-memory model.
module tb_vga_menu_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic [18:0] curAddress;
    logic [7:0]  indexIn;
    logic [23:0] colorIn;
    logic        btn_up, btn_down, btn_left, btn_right, btn_enter;
    logic        sel_ack;
    logic [18:0] addrToRead;
    logic [7:0]  indexOut;
    logic [23:0] colorOut;
    logic [2:0]  sel_index;
    logic        sel_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [18:0] IDLE_ADDR = 19'd1000;

    // reference model state
    int m_sel   = 0;
    bit m_hold  = 0;
    int m_cnt   = 0;
    bit m_phase = 0;

    typedef struct {
        logic [7:0]  idx;
        logic [23:0] col;
        string       tag;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    vga_menu_engine dut (
        .clock      (clock),
        .reset      (reset),
        .curAddress (curAddress),
        .indexIn    (indexIn),
        .colorIn    (colorIn),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_enter  (btn_enter),
        .sel_ack    (sel_ack),
        .addrToRead (addrToRead),
        .indexOut   (indexOut),
        .colorOut   (colorOut),
        .sel_index  (sel_index),
        .sel_valid  (sel_valid)
    );

    function automatic logic [7:0] mem_idx(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
    endfunction

    function automatic logic [23:0] mem_col(input logic [18:0] a);
        return {a, 5'b10101};
    endfunction

    assign indexIn = mem_idx(addrToRead);
    assign colorIn = mem_col(addrToRead);

    function automatic int tb_code(input int opt, input int slot);
        string s;
        byte   c;
        case (opt)
            0:       s = "OPEN";
            1:       s = "SAVE";
            2:       s = "LOAD";
            3:       s = "CONFIG";
            4:       s = "EXIT";
            default: s = "";
        endcase
        if (slot >= s.len()) return 0;
        c = s[slot];
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48 + 1;
        if (c >= 8'h41 && c <= 8'h5A) return int'(c) - 65 + 11;
        return 0;
    endfunction

    function automatic logic [18:0] exp_addr(input int x, input int y);
        for (int i = 0; i < 5; i++) begin
            int lx, ly, k, code;
            lx = 133 + 227*(i/3);
            ly = 227 + 58*(i%3);
            if (x >= lx && x < lx + 7*21 && y >= ly && y < ly + 25) begin
                k    = (x - lx) / 21;
                code = tb_code(i, k);
                if (code == 0) return 19'd1923;
                return 19'(307200 + 525*code + (x - lx - 21*k) + 21*(y - ly));
            end
        end
        if (x >= 204 && x <= 434 && y >= 40 && y <= 195)
            return 19'(25940 + (x - 204) + 640*(y - 40));
        return 19'd1923;
    endfunction

    function automatic bit exp_ovl(input int x, input int y);
        int bx, by;
        bit border, outline;
        border = (x < 3) || (x > 636) || (y < 3) || (y > 476);
        bx = 130 + 227*(m_sel/3);
        by = 224 + 58*(m_sel%3);
        outline = (x >= bx && x <= bx + 152 && y >= by && y <= by + 30) &&
                  (x <= bx + 2 || x >= bx + 150 || y <= by + 2 || y >= by + 28);
        return border || ((!m_phase || m_hold) && outline);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ":index"}, 32'(indexOut), 32'(e.idx));
            check({e.tag, ":color"}, 32'(colorOut), 32'(e.col));
        end
    endtask

    task automatic pixel(input int x, input int y, input string tag);
        logic [18:0] ea;
        bit          ovl;
        exp_t        e;
        ea  = exp_addr(x, y);
        ovl = exp_ovl(x, y);
        @(negedge clock);
        curAddress = 19'(y*640 + x);
        @(posedge clock);
        #1;
        check({tag, ":addr"}, 32'(addrToRead), 32'(ea));
        pop_compare();
        e.idx = ovl ? 8'd7 : mem_idx(ea);
        e.col = mem_col(ea);
        e.tag = tag;
        exp_q.push_back(e);
        if (x == 0 && y == 0) begin
            if (m_cnt == 29) begin
                m_cnt   = 0;
                m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic drain();
        @(negedge clock);
        curAddress = IDLE_ADDR;
        @(posedge clock);
        #1;
        pop_compare();
    endtask

    // mask order {enter, up, down, left, right}; one-cycle press then release
    task automatic press(input logic [4:0] m);
        @(negedge clock);
        {btn_enter, btn_up, btn_down, btn_left, btn_right} = m;
        @(posedge clock);
        #1;
        @(negedge clock);
        {btn_enter, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic ack_pulse();
        @(negedge clock);
        sel_ack = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        sel_ack = 1'b0;
    endtask

    localparam logic [4:0] B_ENTER = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    initial begin
        reset      = 1'b1;
        curAddress = IDLE_ADDR;
        {btn_enter, btn_up, btn_down, btn_left, btn_right} = 5'b00100;
        sel_ack    = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_sel", 32'(sel_index), 32'd0);
        check("rst_valid", 32'(sel_valid), 32'd0);
        check("rst_addr", 32'(addrToRead), 32'd1923);
        check("rst_index", 32'(indexOut), 32'd0);
        check("rst_color", 32'(colorOut), 32'd0);

        // btn_down held through reset release must not register as an edge
        reset = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        btn_down = 1'b0;
        @(posedge clock);
        #1;
        check("held_btn_no_edge", 32'(sel_index), 32'd0);

        press(B_DOWN);  check("down_0_1", 32'(sel_index), 32'd1);
        press(B_DOWN);  check("down_1_2", 32'(sel_index), 32'd2);
        press(B_DOWN);  check("down_wrap_0", 32'(sel_index), 32'd0);
        press(B_UP);    check("up_wrap_2", 32'(sel_index), 32'd2);
        press(B_DOWN);  check("down_2_0", 32'(sel_index), 32'd0);
        press(B_DOWN);  check("down_to_1", 32'(sel_index), 32'd1);
        press(B_RIGHT); check("right_1_4", 32'(sel_index), 32'd4);
        press(B_DOWN);  check("down_col1_wrap_3", 32'(sel_index), 32'd3);
        press(B_LEFT);  check("left_3_0", 32'(sel_index), 32'd0);
        press(B_DOWN);
        press(B_DOWN);  check("down_to_2", 32'(sel_index), 32'd2);
        press(B_RIGHT); check("right_absent_2", 32'(sel_index), 32'd2);
        check("nav_valid_low", 32'(sel_valid), 32'd0);

        press(B_ENTER); check("enter_valid", 32'(sel_valid), 32'd1);
        press(B_DOWN);  check("hold_down_ignored", 32'(sel_index), 32'd2);
        check("hold_valid_kept", 32'(sel_valid), 32'd1);
        ack_pulse();    check("ack_valid_low", 32'(sel_valid), 32'd0);
        press(B_UP);    check("nav_after_ack", 32'(sel_index), 32'd1);
        ack_pulse();    check("ack_in_nav_valid", 32'(sel_valid), 32'd0);
        check("ack_in_nav_sel", 32'(sel_index), 32'd1);
        press(B_UP);    check("up_to_0", 32'(sel_index), 32'd0);
        m_sel = 0;

        pixel(133, 227, "lbl0_slot0");
        pixel(160, 240, "lbl0_slot1");
        pixel(260, 230, "lbl0_blank");
        pixel(130, 224, "box_corner");
        pixel(204, 40,  "logo_first");
        pixel(434, 195, "logo_last");
        pixel(435, 195, "logo_outside");
        pixel(1, 1,     "border_tl");
        pixel(639, 479, "border_br");
        pixel(600, 400, "plain");
        pixel(360, 285, "lbl4_slot0");
        pixel(282, 254, "box_far_corner");
        pixel(200, 235, "box_interior");
        drain();

        press(B_UP | B_ENTER);
        check("upenter_valid", 32'(sel_valid), 32'd1);
        check("upenter_sel", 32'(sel_index), 32'd0);
        m_hold = 1;
        ack_pulse();
        check("upenter_ack", 32'(sel_valid), 32'd0);
        m_hold = 0;

        for (int f = 0; f < 30; f++) pixel(0, 0, "frame_start");
        pixel(130, 224, "box_hidden");
        pixel(131, 250, "box_hidden_left");
        drain();

        press(B_ENTER);
        check("enter2_valid", 32'(sel_valid), 32'd1);
        m_hold = 1;
        pixel(130, 224, "box_hold_visible");
        drain();

        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(sel_valid), 32'd0);
        check("async_rst_addr", 32'(addrToRead), 32'd1923);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_valid", 32'(sel_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
